cond_flag_unit: RTL and testbench

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit_pkg.sv | 28 ++
 rtl/cond_flag_unit_cond_eval.sv | 38 +++
 rtl/cond_flag_unit.sv | 63 ++++++
 tb/tb_cond_flag_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cond_flag_unit_pkg.sv
// Shared condition-code definitions: flag bit positions and ARM-style condition-field encodings.
package cond_flag_unit_pkg;

   localparam int unsigned FlagV = 3;
   localparam int unsigned FlagC = 2;
   localparam int unsigned FlagZ = 1;
   localparam int unsigned FlagN = 0;

   typedef enum logic [3:0] {
      CondEq = 4'b0000,
      CondNe = 4'b0001,
      CondCs = 4'b0010,
      CondCc = 4'b0011,
      CondMi = 4'b0100,
      CondPl = 4'b0101,
      CondVs = 4'b0110,
      CondVc = 4'b0111,
      CondHi = 4'b1000,
      CondLs = 4'b1001,
      CondGe = 4'b1010,
      CondLt = 4'b1011,
      CondGt = 4'b1100,
      CondLe = 4'b1101,
      CondAl = 4'b1110,
      CondNv = 4'b1111
   } cond_e;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Pure combinational evaluation of a 4-bit condition field against {V,C,Z,N} flags.
module cond_eval
   import cond_flag_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n    = flags[FlagN];
      z    = flags[FlagZ];
      c    = flags[FlagC];
      v    = flags[FlagV];
      pass = 1'b0;
      unique case (cond_e'(cond))
         CondEq: pass = z;
         CondNe: pass = ~z;
         CondCs: pass = c;
         CondCc: pass = ~c;
         CondMi: pass = n;
         CondPl: pass = ~n;
         CondVs: pass = v;
         CondVc: pass = ~v;
         CondHi: pass = c & ~z;
         CondLs: pass = ~c | z;
         CondGe: pass = (n == v);
         CondLt: pass = (n != v);
         CondGt: pass = ~z & (n == v);
         CondLe: pass = z | (n != v);
         CondAl: pass = 1'b1;
         CondNv: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Committed flag register with same-cycle EX bypass, plus ID-stage condition evaluation
// registered across the ID/EX boundary.
module cond_flag_unit
   import cond_flag_unit_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic [3:0] flags_in,
   input  logic       s_in,
   input  logic       ex_valid_in,
   input  logic [3:0] cond_in,
   input  logic       stall_in,
   input  logic       flush_in,
   output logic [3:0] cc_out,
   output logic       carry_out,
   output logic       cond_pass_out,
   output logic       cond_pass_q_out
);

   logic [3:0] cc_d, cc_q;
   logic       cond_pass_d, cond_pass_q;
   logic       flag_wr;
   logic [3:0] eff_flags;
   logic       pass;

   cond_eval u_cond_eval (
      .cond  (cond_in),
      .flags (eff_flags),
      .pass  (pass)
   );

   always_comb begin
      flag_wr   = ex_valid_in & s_in;
      eff_flags = flag_wr ? flags_in : cc_q;
      cc_d      = (flag_wr & ~stall_in) ? flags_in : cc_q;
      // Flush wins over stall; it only squashes the ID-stage result.
      if (flush_in) begin
         cond_pass_d = 1'b0;
      end else if (stall_in) begin
         cond_pass_d = cond_pass_q;
      end else begin
         cond_pass_d = pass;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         cc_q        <= RESET_FLAGS;
         cond_pass_q <= 1'b0;
      end else begin
         cc_q        <= cc_d;
         cond_pass_q <= cond_pass_d;
      end
   end

   assign cc_out          = cc_q;
   assign carry_out       = eff_flags[FlagC];
   assign cond_pass_out   = pass;
   assign cond_pass_q_out = cond_pass_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Table-driven bench: combinational outputs checked mid-cycle, registered results via a queue.
module tb_cond_flag_unit;

   logic       clk;
   logic       reset_in;
   logic [3:0] flags_in;
   logic       s_in;
   logic       ex_valid_in;
   logic [3:0] cond_in;
   logic       stall_in;
   logic       flush_in;
   logic [3:0] cc_out;
   logic       carry_out;
   logic       cond_pass_out;
   logic       cond_pass_q_out;

   cond_flag_unit #(
      .RESET_FLAGS (4'b0000)
   ) dut (
      .clk_in          (clk),
      .reset_in        (reset_in),
      .flags_in        (flags_in),
      .s_in            (s_in),
      .ex_valid_in     (ex_valid_in),
      .cond_in         (cond_in),
      .stall_in        (stall_in),
      .flush_in        (flush_in),
      .cc_out          (cc_out),
      .carry_out       (carry_out),
      .cond_pass_out   (cond_pass_out),
      .cond_pass_q_out (cond_pass_q_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ev;
      logic       s;
      logic [3:0] flags;
      logic [3:0] cond;
      logic       st;
      logic       fl;
      logic       e_pass;
      logic       e_carry;
      logic [3:0] e_cc;
      logic       e_pq;
   } vec_t;

   typedef struct {
      logic [3:0] cc;
      logic       pq;
      int         idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t tv(logic rst, logic ev, logic s, logic [3:0] flags, logic [3:0] cond,
                               logic st, logic fl, logic e_pass, logic e_carry,
                               logic [3:0] e_cc, logic e_pq);
      vec_t v;
      v.rst = rst; v.ev = ev; v.s = s; v.flags = flags; v.cond = cond;
      v.st = st; v.fl = fl; v.e_pass = e_pass; v.e_carry = e_carry;
      v.e_cc = e_cc; v.e_pq = e_pq;
      return v;
   endfunction

   task automatic check(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      // rst ev s flags cond st fl | pass carry cc_next pq_next
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b1110, 0, 0, 1, 0, 4'b0000, 1)); // AL
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 0)); // NV
      vecs.push_back(tv(0, 1, 1, 4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0010, 1)); // EQ bypass
      vecs.push_back(tv(0, 1, 1, 4'b0100, 4'b0010, 1, 0, 1, 1, 4'b0010, 1)); // stalled update
      vecs.push_back(tv(0, 1, 1, 4'b0100, 4'b0011, 1, 0, 0, 1, 4'b0010, 1)); // still stalled
      vecs.push_back(tv(0, 1, 1, 4'b0100, 4'b0011, 0, 0, 0, 1, 4'b0100, 0)); // stall released
      vecs.push_back(tv(0, 1, 1, 4'b1001, 4'b1010, 0, 0, 1, 0, 4'b1001, 1)); // GE
      vecs.push_back(tv(0, 1, 1, 4'b0001, 4'b1011, 0, 0, 1, 0, 4'b0001, 1)); // LT back-to-back
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b1011, 0, 0, 1, 0, 4'b0001, 1)); // LT committed
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b1110, 1, 1, 1, 0, 4'b0001, 0)); // flush+stall
      vecs.push_back(tv(0, 1, 1, 4'b0110, 4'b1000, 0, 1, 0, 1, 4'b0110, 0)); // flush keeps update
      vecs.push_back(tv(0, 0, 1, 4'b1111, 4'b0000, 0, 0, 1, 1, 4'b0110, 1)); // ev=0 ignored
      vecs.push_back(tv(0, 1, 0, 4'b1111, 4'b0001, 0, 0, 0, 1, 4'b0110, 0)); // s=0 ignored
      vecs.push_back(tv(1, 1, 1, 4'b1010, 4'b1110, 1, 0, 1, 0, 4'b0000, 0)); // reset w/ update
      vecs.push_back(tv(0, 1, 1, 4'b1000, 4'b1100, 0, 0, 0, 0, 4'b1000, 0)); // GT
      vecs.push_back(tv(0, 1, 1, 4'b0010, 4'b1101, 0, 0, 1, 0, 4'b0010, 1)); // LE
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b1001, 0, 0, 1, 0, 4'b0010, 1)); // LS via Z
      vecs.push_back(tv(0, 1, 1, 4'b0100, 4'b1001, 0, 0, 0, 1, 4'b0100, 0)); // LS C&!Z
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b0101, 0, 0, 1, 1, 4'b0100, 1)); // PL
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b0110, 1, 0, 0, 1, 4'b0100, 1)); // VS, stall
      vecs.push_back(tv(1, 0, 0, 4'b0000, 4'b0111, 1, 0, 1, 1, 4'b0000, 0)); // reset mid-stall
      vecs.push_back(tv(0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0, 1, 4'b1111, 0)); // NV
      vecs.push_back(tv(0, 0, 0, 4'b0000, 4'b0100, 0, 0, 1, 1, 4'b1111, 1)); // MI

      reset_in = 1'b1; flags_in = '0; s_in = 0; ex_valid_in = 0;
      cond_in = 4'b1110; stall_in = 0; flush_in = 0;
      @(posedge clk); #1;
      check("reset_cc", cc_out, 4'b0000);
      check("reset_pq", {3'b0, cond_pass_q_out}, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         reset_in    = vecs[i].rst;
         ex_valid_in = vecs[i].ev;
         s_in        = vecs[i].s;
         flags_in    = vecs[i].flags;
         cond_in     = vecs[i].cond;
         stall_in    = vecs[i].st;
         flush_in    = vecs[i].fl;
         #1;
         check($sformatf("v%0d_pass", i), {3'b0, cond_pass_out}, {3'b0, vecs[i].e_pass});
         check($sformatf("v%0d_carry", i), {3'b0, carry_out}, {3'b0, vecs[i].e_carry});
         e.cc = vecs[i].e_cc; e.pq = vecs[i].e_pq; e.idx = i;
         sbq.push_back(e);
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got size 0 expected 1");
         end else begin
            e = sbq.pop_front();
            check($sformatf("v%0d_cc", e.idx), cc_out, e.cc);
            check($sformatf("v%0d_pq", e.idx), {3'b0, cond_pass_q_out}, {3'b0, e.pq});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
